// File: rtl/branch_outcome_predictor_pkg.sv
// Shared encodings and helpers for the sail core branch outcome predictor.
// 2-bit saturating counter states; the MSB alone decides taken/not-taken.
package branch_outcome_predictor_pkg;

  localparam logic [1:0] kSAIL_BP_SNT = 2'b00;
  localparam logic [1:0] kSAIL_BP_WNT = 2'b01;
  localparam logic [1:0] kSAIL_BP_WT  = 2'b10;
  localparam logic [1:0] kSAIL_BP_ST  = 2'b11;

  localparam logic [1:0] kSAIL_BP_RESET = kSAIL_BP_WNT;

  function automatic logic bp_predict_taken(input logic [1:0] cnt);
    return cnt[1];
  endfunction

endpackage

// File: rtl/branch_outcome_predictor_sat_counter2.sv
// Next-state logic for one 2-bit saturating counter: step toward the
// observed outcome, holding at the strong states.
module sat_counter2
  import branch_outcome_predictor_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      unique case (cnt_i)
        kSAIL_BP_SNT: cnt_o = kSAIL_BP_WNT;
        kSAIL_BP_WNT: cnt_o = kSAIL_BP_WT;
        kSAIL_BP_WT:  cnt_o = kSAIL_BP_ST;
        kSAIL_BP_ST:  cnt_o = kSAIL_BP_ST;
        default:      cnt_o = cnt_i;
      endcase
    end else begin
      unique case (cnt_i)
        kSAIL_BP_SNT: cnt_o = kSAIL_BP_SNT;
        kSAIL_BP_WNT: cnt_o = kSAIL_BP_SNT;
        kSAIL_BP_WT:  cnt_o = kSAIL_BP_WNT;
        kSAIL_BP_ST:  cnt_o = kSAIL_BP_WT;
        default:      cnt_o = cnt_i;
      endcase
    end
  end

endmodule

// File: rtl/branch_outcome_predictor.sv
// PC-indexed 2-bit counter branch predictor with target adder, execute-stage
// training, mispredict flag and free-running branch/mispredict statistics.
module branch_outcome_predictor
  import branch_outcome_predictor_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  input  logic [31:0] pred_offset,
  output logic        prediction,
  output logic [31:0] branch_addr,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic        res_predicted,
  output logic        mispredict,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int DEPTH = 1 << IDX_BITS;

  // Kept in flops rather than RAM so a single reset cycle clears every entry.
  logic [1:0] table_q [DEPTH];
  logic [1:0] table_d [DEPTH];

  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] res_idx;
  logic [1:0]          upd_cur;
  logic [1:0]          upd_next;

  logic [31:0] branch_count_q;
  logic [31:0] branch_count_d;
  logic [31:0] mispredict_count_q;
  logic [31:0] mispredict_count_d;

  assign pred_idx = pred_pc[IDX_BITS+1:2];
  assign res_idx  = res_pc[IDX_BITS+1:2];

  // Lookup reads registered state only, so a same-cycle update is not seen.
  assign prediction  = pred_valid & bp_predict_taken(table_q[pred_idx]);
  assign branch_addr = pred_pc + pred_offset;
  assign mispredict  = res_valid & (res_taken ^ res_predicted);

  assign upd_cur = table_q[res_idx];

  sat_counter2 u_sat_counter2 (
    .cnt_i   (upd_cur),
    .taken_i (res_taken),
    .cnt_o   (upd_next)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign table_d[gi] = (res_valid && (res_idx == IDX_BITS'(gi))) ? upd_next : table_q[gi];
  end

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (res_valid) begin
      branch_count_d = branch_count_q + 32'd1;
    end
    if (mispredict) begin
      mispredict_count_d = mispredict_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= kSAIL_BP_RESET;
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= table_d[i];
      end
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

  // Only the index bits of each PC are used; the rest are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                            res_pc[31:IDX_BITS+2], res_pc[1:0]};

endmodule

// File: tb/tb_branch_outcome_predictor.sv
// Directed self-checking bench for branch_outcome_predictor (IDX_BITS=4).
module tb_branch_outcome_predictor;

  logic        clk;
  logic        rst_n;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic [31:0] pred_offset;
  logic        prediction;
  logic [31:0] branch_addr;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic        res_predicted;
  logic        mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int tests;
  int errors;

  branch_outcome_predictor #(.IDX_BITS(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .pred_offset      (pred_offset),
    .prediction       (prediction),
    .branch_addr      (branch_addr),
    .res_valid        (res_valid),
    .res_pc           (res_pc),
    .res_taken        (res_taken),
    .res_predicted    (res_predicted),
    .mispredict       (mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One resolve across one rising edge; inputs change only at negedges.
  task automatic resolve(input logic [31:0] pc, input logic taken, input logic predicted);
    @(negedge clk);
    res_valid     = 1'b1;
    res_pc        = pc;
    res_taken     = taken;
    res_predicted = predicted;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    $display("[TB] resolve pc=%08h taken=%0b predicted=%0b", pc, taken, predicted);
  endtask

  task automatic lookup(input logic [31:0] pc);
    pred_valid = 1'b1;
    pred_pc    = pc;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    res_valid = 1'b1; res_pc = 32'h40; res_taken = 1'b1; res_predicted = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1; res_valid = 1'b0;
    #1;
    tests++;
    if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict got=%0b exp=0", mispredict); end
    pred_valid = 1'b0; pred_pc = 32'h40; #1;
    tests++;
    if (prediction !== 1'b0) begin errors++; $display("FAIL reset_pred_invalid got=%0b exp=0", prediction); end
    for (int i = 0; i < 4; i++) begin
      lookup(32'h100 + 32'(i * 4));
      tests++;
      if (prediction !== 1'b0) begin errors++; $display("FAIL reset_pred pc=%08h got=%0b exp=0", pred_pc, prediction); end
    end
    tests++;
    if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", branch_count, mispredict_count);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_training();
    @(negedge clk);
    res_valid = 1'b1; res_pc = 32'h40; res_taken = 1'b1; res_predicted = 1'b0;
    #1;
    tests++;
    if (mispredict !== 1'b1) begin errors++; $display("FAIL train_mispredict got=%0b exp=1", mispredict); end
    res_valid = 1'b0;
    resolve(32'h40, 1'b1, 1'b0);
    lookup(32'h40);
    tests++;
    if (prediction !== 1'b1) begin errors++; $display("FAIL train_one_step got=%0b exp=1", prediction); end
    resolve(32'h40, 1'b1, 1'b0);
    lookup(32'h40);
    tests++;
    if (prediction !== 1'b1) begin errors++; $display("FAIL train_pred got=%0b exp=1", prediction); end
    tests++;
    if (branch_count !== 32'd2 || mispredict_count !== 32'd2) begin
      errors++; $display("FAIL train_counts got=%0d/%0d exp=2/2", branch_count, mispredict_count);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) resolve(32'h40, 1'b1, 1'b1);
    resolve(32'h40, 1'b0, 1'b1);
    lookup(32'h40);
    tests++;
    if (prediction !== 1'b1) begin errors++; $display("FAIL sat_high_one_nt got=%0b exp=1", prediction); end
    resolve(32'h40, 1'b0, 1'b1);
    lookup(32'h40);
    tests++;
    if (prediction !== 1'b0) begin errors++; $display("FAIL sat_high_two_nt got=%0b exp=0", prediction); end
    // Low side: drive idx 2 to 00 and beyond, then walk back up.
    for (int i = 0; i < 3; i++) resolve(32'h48, 1'b0, 1'b0);
    resolve(32'h48, 1'b1, 1'b0);
    lookup(32'h48);
    tests++;
    if (prediction !== 1'b0) begin errors++; $display("FAIL sat_low_one_t got=%0b exp=0", prediction); end
    resolve(32'h48, 1'b1, 1'b0);
    lookup(32'h48);
    tests++;
    if (prediction !== 1'b1) begin errors++; $display("FAIL sat_low_two_t got=%0b exp=1", prediction); end
    tests++;
    if (branch_count !== 32'd14 || mispredict_count !== 32'd6) begin
      errors++; $display("FAIL sat_counts got=%0d/%0d exp=14/6", branch_count, mispredict_count);
    end
  endtask

  task automatic test_aliasing();
    resolve(32'h44, 1'b1, 1'b1);
    resolve(32'h44, 1'b1, 1'b1);
    lookup(32'h84);
    tests++;
    if (prediction !== 1'b1) begin errors++; $display("FAIL alias_84 got=%0b exp=1", prediction); end
    lookup(32'h4C);
    tests++;
    if (prediction !== 1'b0) begin errors++; $display("FAIL alias_neighbour_4c got=%0b exp=0", prediction); end
    lookup(32'h47);
    tests++;
    if (prediction !== 1'b1) begin errors++; $display("FAIL alias_low_bits got=%0b exp=1", prediction); end
    // Entry is 11; one not-taken -> 10, still taken.
    resolve(32'h44, 1'b0, 1'b1);
    @(negedge clk);
    pred_valid = 1'b1; pred_pc = 32'h44;
    res_valid = 1'b1; res_pc = 32'h44; res_taken = 1'b0; res_predicted = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (prediction !== 1'b0) begin errors++; $display("FAIL same_cycle_after got=%0b exp=0", prediction); end
    res_valid = 1'b0;
    $display("[TB] same-cycle lookup/update pc=00000044");
    tests++;
    if (branch_count !== 32'd18 || mispredict_count !== 32'd8) begin
      errors++; $display("FAIL alias_counts got=%0d/%0d exp=18/8", branch_count, mispredict_count);
    end
  endtask

  task automatic test_same_cycle_old();
    // Entry idx 0 holds 01; resolve taken while looking it up.
    @(negedge clk);
    pred_valid = 1'b1; pred_pc = 32'h40;
    res_valid = 1'b1; res_pc = 32'h00; res_taken = 1'b1; res_predicted = 1'b0;
    #1;
    tests++;
    if (prediction !== 1'b0) begin errors++; $display("FAIL same_cycle_old got=%0b exp=0", prediction); end
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    tests++;
    if (prediction !== 1'b1) begin errors++; $display("FAIL same_cycle_new got=%0b exp=1", prediction); end
    $display("[TB] same-cycle lookup/update pc=00000040");
  endtask

  task automatic test_target();
    logic [31:0] pcs  [3];
    logic [31:0] offs [3];
    logic [31:0] exps [3];
    pcs[0] = 32'hFFFF_FFF0; offs[0] = 32'h0000_0020; exps[0] = 32'h0000_0010;
    pcs[1] = 32'h0000_0100; offs[1] = 32'hFFFF_FFF8; exps[1] = 32'h0000_00F8;
    pcs[2] = 32'h1234_0000; offs[2] = 32'h0000_0ABC; exps[2] = 32'h1234_0ABC;
    for (int i = 0; i < 3; i++) begin
      pred_valid = i[0]; pred_pc = pcs[i]; pred_offset = offs[i];
      #1;
      tests++;
      if (branch_addr !== exps[i]) begin
        errors++; $display("FAIL target_%0d got=%08h exp=%08h", i, branch_addr, exps[i]);
      end
      $display("[TB] target pc=%08h off=%08h addr=%08h", pcs[i], offs[i], branch_addr);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      res_valid = 1'b1; res_pc = 32'h50 + 32'(i * 4); res_taken = 1'b1; res_predicted = i[0];
      @(negedge clk);
    end
    res_valid = 1'b0;
    lookup(32'h50);
    tests++;
    if (prediction !== 1'b1) begin errors++; $display("FAIL b2b_pred got=%0b exp=1", prediction); end
    tests++;
    if (branch_count !== 32'd23 || mispredict_count !== 32'd11) begin
      errors++; $display("FAIL b2b_counts got=%0d/%0d exp=23/11", branch_count, mispredict_count);
    end
    $display("[TB] back-to-back 4 resolves");
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.branch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_count_q;
    #1;
    tests++;
    if (branch_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got=%08h exp=ffffffff", branch_count); end
    resolve(32'h60, 1'b1, 1'b1);
    tests++;
    if (branch_count !== 32'd0 || mispredict_count !== 32'd11) begin
      errors++; $display("FAIL wrap_counts got=%08h/%0d exp=00000000/11", branch_count, mispredict_count);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    rst_n = 1'b0;
    res_valid = 1'b1; res_pc = 32'h40; res_taken = 1'b1; res_predicted = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; res_valid = 1'b0;
    lookup(32'h40);
    tests++;
    if (prediction !== 1'b0) begin errors++; $display("FAIL rstprio_pred got=%0b exp=0", prediction); end
    tests++;
    if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      errors++; $display("FAIL rstprio_counts got=%0d/%0d exp=0/0", branch_count, mispredict_count);
    end
    $display("[TB] reset with concurrent resolve");
    // A single taken resolve crosses 01 -> 10, proving the entry was 01.
    resolve(32'h40, 1'b1, 1'b0);
    lookup(32'h40);
    tests++;
    if (prediction !== 1'b1) begin errors++; $display("FAIL rstprio_wnt got=%0b exp=1", prediction); end
  endtask

  initial begin
    tests = 0; errors = 0;
    rst_n = 1'b0; pred_valid = 1'b0; pred_pc = '0; pred_offset = '0;
    res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_predicted = 1'b0;
    test_reset();
    test_training();
    test_saturation();
    test_aliasing();
    test_same_cycle_old();
    test_target();
    test_back_to_back();
    test_wrap();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
